// File: rtl/prpg_pkg.sv
// Shared definitions for the PRPG pattern generator and its signature analyzer:
// session state encoding, distance width and a generic popcount.
package prpg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int PRPG_W = 8;
   localparam int HD_W   = $clog2(PRPG_W + 1);

   // Callers zero-extend narrower vectors; any width up to 64 bits is supported.
   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/prpg_sig_analyzer_misr_reg.sv
// Multiple-input signature register: shift-left Galois MISR that folds d in on each enable.
// load restores the seed and takes priority over en.
module misr_reg #(
   parameter int           W         = 8,
   parameter logic [W-1:0] MISR_POLY = 8'h1D,
   parameter logic [W-1:0] MISR_SEED = 8'h00
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] sig
);

   logic [W-1:0] sig_nxt;

   assign sig_nxt = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? MISR_POLY : '0) ^ d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sig <= MISR_SEED;
      end else if (load) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= sig_nxt;
      end
   end

endmodule

// File: rtl/prpg_sig_analyzer.sv
// Consumes num_pat PRPG patterns, accumulating pairwise Hamming distances and a MISR signature.
// done pulses the cycle after the final accept; pat_ready depends on state only, so stalls simply hold.
module prpg_sig_analyzer
   import prpg_pkg::*;
#(
   parameter int           W         = 8,
   parameter int           CNT_W     = 16,
   parameter logic [W-1:0] MISR_POLY = 8'h1D,
   parameter logic [W-1:0] MISR_SEED = 8'h00
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [CNT_W-1:0]              num_pat,
   input  logic                          pat_valid,
   input  logic [W-1:0]                  pat,
   output logic                          pat_ready,
   output logic                          busy,
   output logic                          done,
   output logic [W-1:0]                  signature,
   output logic [$clog2(W+1)-1:0]        hd_last,
   output logic [$clog2(W+1)-1:0]        hd_max,
   output logic [CNT_W+$clog2(W+1)-1:0]  hd_sum,
   output logic [CNT_W-1:0]              pat_cnt
);

   localparam int HDW   = $clog2(W + 1);
   localparam int SUM_W = CNT_W + HDW;

   state_t             state, state_nxt;
   logic               accept;
   logic               misr_load;
   logic [HDW-1:0]     hd;
   logic [CNT_W-1:0]   num_pat_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic [W-1:0]       prev_q;

   assign accept  = pat_valid & pat_ready;
   assign cnt_inc = pat_cnt + CNT_W'(1);
   assign hd      = HDW'(popcount(64'(pat ^ prev_q)));

   always_comb begin
      state_nxt = state;
      pat_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      misr_load = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               misr_load = 1'b1;
               state_nxt = (num_pat == '0) ? DONE : FIRST;
            end
         end
         FIRST: begin
            pat_ready = 1'b1;
            busy      = 1'b1;
            if (accept) begin
               state_nxt = (num_pat_q == CNT_W'(1)) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            pat_ready = 1'b1;
            busy      = 1'b1;
            if (accept && (cnt_inc == num_pat_q)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // The first pattern of a session only seeds prev; distances start with the second.
   always_ff @(posedge clk) begin
      if (rst) begin
         num_pat_q <= '0;
         prev_q    <= '0;
         hd_last   <= '0;
         hd_max    <= '0;
         hd_sum    <= '0;
         pat_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  num_pat_q <= num_pat;
                  hd_last   <= '0;
                  hd_max    <= '0;
                  hd_sum    <= '0;
                  pat_cnt   <= '0;
               end
            end
            FIRST: begin
               if (accept) begin
                  prev_q  <= pat;
                  pat_cnt <= CNT_W'(1);
               end
            end
            ACCUM: begin
               if (accept) begin
                  prev_q  <= pat;
                  hd_last <= hd;
                  hd_sum  <= hd_sum + SUM_W'(hd);
                  if (hd > hd_max) begin
                     hd_max <= hd;
                  end
                  pat_cnt <= cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

   misr_reg #(
      .W         (W),
      .MISR_POLY (MISR_POLY),
      .MISR_SEED (MISR_SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misr_load),
      .en   (accept),
      .d    (pat),
      .sig  (signature)
   );

endmodule

// File: tb/tb_prpg_sig_analyzer.sv
// Randomized session bench for prpg_sig_analyzer against a list-based reference model.
module tb_prpg_sig_analyzer;

   localparam int W     = 8;
   localparam int CNT_W = 16;
   localparam int HDW   = $clog2(W + 1);

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [CNT_W-1:0]     num_pat = '0;
   logic                 pat_valid = 1'b0;
   logic [W-1:0]         pat = '0;
   logic                 pat_ready;
   logic                 busy;
   logic                 done;
   logic [W-1:0]         signature;
   logic [HDW-1:0]       hd_last;
   logic [HDW-1:0]       hd_max;
   logic [CNT_W+HDW-1:0] hd_sum;
   logic [CNT_W-1:0]     pat_cnt;

   int checks   = 0;
   int failures = 0;

   bit [7:0] q[$];
   bit [7:0] exp_sig;
   int       exp_sum, exp_max, exp_last;

   prpg_sig_analyzer #(
      .W         (W),
      .CNT_W     (CNT_W),
      .MISR_POLY (8'h1D),
      .MISR_SEED (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_pat   (num_pat),
      .pat_valid (pat_valid),
      .pat       (pat),
      .pat_ready (pat_ready),
      .busy      (busy),
      .done      (done),
      .signature (signature),
      .hd_last   (hd_last),
      .hd_max    (hd_max),
      .hd_sum    (hd_sum),
      .pat_cnt   (pat_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Signature as polynomial division over GF(2): multiply by x, reduce mod 0x11D, add pattern.
   task automatic model();
      bit [8:0] s;
      int d;
      exp_sig  = 8'h00;
      exp_sum  = 0;
      exp_max  = 0;
      exp_last = 0;
      for (int i = 0; i < q.size(); i++) begin
         s = {exp_sig, 1'b0};
         if (s[8]) s = s ^ 9'h11D;
         exp_sig = s[7:0] ^ q[i];
         if (i > 0) begin
            d = $countones(q[i] ^ q[i-1]);
            exp_sum += d;
            exp_last = d;
            if (d > exp_max) exp_max = d;
         end
      end
   endtask

   task automatic check_results(input string tag);
      model();
      check({tag, "_sig"},  64'(signature), 64'(exp_sig));
      check({tag, "_sum"},  64'(hd_sum),    64'(exp_sum));
      check({tag, "_max"},  64'(hd_max),    64'(exp_max));
      check({tag, "_last"}, 64'(hd_last),   64'(exp_last));
      check({tag, "_cnt"},  64'(pat_cnt),   64'(q.size()));
   endtask

   // Runs one session over the patterns in q; stall cycles may carry ignored start pulses.
   task automatic run_session(input string tag, input int max_stall, input bit spam);
      int n;
      n = q.size();
      start   = 1'b1;
      num_pat = CNT_W'(n);
      tick();
      start = 1'b0;
      if (n == 0) begin
         check({tag, "_rdy0"}, 64'(pat_ready), 64'(0));
         check({tag, "_done"}, 64'(done), 64'(1));
      end else begin
         check({tag, "_busy"}, 64'(busy), 64'(1));
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(max_stall, 0)) begin
               pat_valid = 1'b0;
               pat       = 8'($urandom);
               start     = spam;
               num_pat   = CNT_W'($urandom_range(3, 0));
               tick();
            end
            start     = 1'b0;
            pat_valid = 1'b1;
            pat       = q[i];
            if (i == 0) check({tag, "_rdy"}, 64'(pat_ready), 64'(1));
            tick();
            pat_valid = 1'b0;
            if (i < n - 1) check({tag, "_early"}, 64'(done), 64'(0));
         end
         check({tag, "_done"}, 64'(done), 64'(1));
      end
      check_results(tag);
      tick();
      check({tag, "_pulse"}, 64'(done), 64'(0));
      check({tag, "_idle"},  64'(busy), 64'(0));
   endtask

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      check("rst_rdy",  64'(pat_ready), 64'(0));
      check("rst_busy", 64'(busy),      64'(0));
      check("rst_done", 64'(done),      64'(0));
      check("rst_sig",  64'(signature), 64'(0));
      check("rst_sum",  64'(hd_sum),    64'(0));
      check("rst_cnt",  64'(pat_cnt),   64'(0));

      q = {};
      run_session("n0", 0, 1'b0);
      q = {8'hA5};
      run_session("single", 0, 1'b0);
      q = {8'h01, 8'h80};
      run_session("pair", 0, 1'b0);
      q = {8'h80, 8'h00};
      run_session("fold", 1, 1'b0);

      // Fixed three-cycle stalls with start pulses during them.
      q = {8'hFF, 8'h00, 8'h0F, 8'h0F};
      start   = 1'b1;
      num_pat = 16'd4;
      tick();
      for (int i = 0; i < 4; i++) begin
         repeat (3) begin
            pat_valid = 1'b0;
            start     = 1'b1;
            num_pat   = 16'd1;
            tick();
         end
         start     = 1'b0;
         pat_valid = 1'b1;
         pat       = q[i];
         tick();
         pat_valid = 1'b0;
      end
      check("stall_done", 64'(done), 64'(1));
      check_results("stall");
      tick();

      // Patterns offered in IDLE must be ignored.
      pat_valid = 1'b1;
      repeat (3) begin
         pat = 8'($urandom);
         tick();
      end
      pat_valid = 1'b0;
      check("idle_sig", 64'(signature), 64'(exp_sig));
      check("idle_cnt", 64'(pat_cnt),   64'(4));

      // Reset mid-session.
      start   = 1'b1;
      num_pat = 16'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pat_valid = 1'b1;
         pat       = 8'($urandom);
         tick();
      end
      pat_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      begin
         int dcnt;
         dcnt = 0;
         for (int i = 0; i < 4; i++) begin
            if (done) dcnt++;
            tick();
         end
         check("mrst_nodone", 64'(dcnt), 64'(0));
      end
      check("mrst_rdy",  64'(pat_ready), 64'(0));
      check("mrst_busy", 64'(busy),      64'(0));
      check("mrst_sig",  64'(signature), 64'(0));
      check("mrst_sum",  64'(hd_sum),    64'(0));
      check("mrst_max",  64'(hd_max),    64'(0));
      check("mrst_last", 64'(hd_last),   64'(0));
      check("mrst_cnt",  64'(pat_cnt),   64'(0));
      q = {8'h3C, 8'hC3, 8'h00};
      run_session("after_rst", 1, 1'b0);

      for (int s = 0; s < 25; s++) begin
         q = {};
         repeat ($urandom_range(7, 0)) q.push_back(8'($urandom));
         run_session("rand", 2, 1'($urandom));
      end
      q = {};
      repeat (40) q.push_back(8'($urandom));
      run_session("long", 1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
